// File: rtl/i2s_sample_tx_pkg.sv
// Shared constants and types for the I2S sample transmitter.
// Holds default widths, the frame length in clk cycles and the sample type.
package i2s_sample_tx_pkg;

   localparam int DEF_SAMPLE_WIDTH = 16;
   localparam int DEF_BCLK_DIV     = 4;
   localparam int DEF_LATCH_DELAY  = 2;

   // clk cycles between two new_sample_ready pulses
   localparam int FRAME_CLKS = 4 * DEF_SAMPLE_WIDTH * DEF_BCLK_DIV;

   typedef logic signed [DEF_SAMPLE_WIDTH-1:0] sample_t;

   function automatic int frame_clks(input int sw, input int div);
      return 4 * sw * div;
   endfunction

endpackage

// File: rtl/i2s_sample_tx_bclk_gen.sv
// Bit-clock divider: toggles bclk every BCLK_DIV clk cycles.
// Ports: clk, reset (async high) in; bclk and fall_evt (1-clk strobe on the
// cycle whose edge drives bclk low) out.
module i2s_sample_tx_bclk_gen #(
   parameter int BCLK_DIV = 4
) (
   input  logic clk,
   input  logic reset,
   output logic bclk,
   output logic fall_evt
);

   localparam int DW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
   localparam logic [DW-1:0] DIV_M1 = DW'(BCLK_DIV - 1);

   logic [DW-1:0] div_cnt;
   logic          wrap;

   assign wrap     = (div_cnt == DIV_M1);
   assign fall_evt = wrap & bclk;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         div_cnt <= '0;
         bclk    <= 1'b0;
      end else begin
         div_cnt <= wrap ? '0 : div_cnt + 1'b1;
         if (wrap) begin
            bclk <= ~bclk;
         end
      end
   end

endmodule

// File: rtl/i2s_sample_tx.sv
// Left-justified I2S frame master: paces upstream with new_sample_ready,
// captures the mono sample and sends it MSB-first in both channel slots.
// Ports: clk, reset, in_sample, tx_enable in; new_sample_ready, bclk,
// lrclk, sdata out (all registered).
module i2s_sample_tx
   import i2s_sample_tx_pkg::*;
#(
   parameter int SAMPLE_WIDTH = DEF_SAMPLE_WIDTH,
   parameter int BCLK_DIV     = DEF_BCLK_DIV,
   parameter int LATCH_DELAY  = DEF_LATCH_DELAY
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic signed [SAMPLE_WIDTH-1:0] in_sample,
   input  logic                           tx_enable,
   output logic                           new_sample_ready,
   output logic                           bclk,
   output logic                           lrclk,
   output logic                           sdata
);

   localparam int FW = 2 * SAMPLE_WIDTH;
   localparam int BW = $clog2(FW);
   localparam int CW = $clog2(LATCH_DELAY + 1);

   localparam logic [BW-1:0] LAST  = BW'(FW - 1);
   localparam logic [BW-1:0] HALF  = BW'(SAMPLE_WIDTH);
   localparam logic [CW-1:0] LD_M1 = CW'(LATCH_DELAY - 1);
   localparam logic [CW-1:0] ONE   = CW'(1);

   logic                    fall_evt;
   logic [BW-1:0]           bit_cnt;
   logic [BW-1:0]           bit_nxt;
   logic [FW-1:0]           shift_reg;
   logic [SAMPLE_WIDTH-1:0] hold_reg;
   logic [CW-1:0]           latch_cnt;

   i2s_sample_tx_bclk_gen #(
      .BCLK_DIV (BCLK_DIV)
   ) u_bclk_gen (
      .clk      (clk),
      .reset    (reset),
      .bclk     (bclk),
      .fall_evt (fall_evt)
   );

   assign bit_nxt = bit_cnt + 1'b1;

   // Bit counter and shifter. Reset value LAST makes the first falling
   // edge after reset a frame boundary.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bit_cnt          <= LAST;
         lrclk            <= 1'b0;
         shift_reg        <= '0;
         sdata            <= 1'b0;
         new_sample_ready <= 1'b0;
      end else begin
         new_sample_ready <= 1'b0;
         if (fall_evt) begin
            if (bit_cnt == LAST) begin
               bit_cnt          <= '0;
               lrclk            <= 1'b0;
               shift_reg        <= {hold_reg, hold_reg};
               sdata            <= tx_enable & hold_reg[SAMPLE_WIDTH-1];
               new_sample_ready <= 1'b1;
            end else begin
               bit_cnt   <= bit_nxt;
               lrclk     <= (bit_nxt >= HALF);
               shift_reg <= {shift_reg[FW-2:0], 1'b0};
               // shifting continues while masked so alignment is kept
               sdata     <= tx_enable & shift_reg[FW-2];
            end
         end
      end
   end

   // Capture in_sample LATCH_DELAY cycles after the pulse edge.
   // latch_cnt == 0 means idle; a new pulse always restarts it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hold_reg  <= '0;
         latch_cnt <= '0;
      end else if (new_sample_ready) begin
         if (LATCH_DELAY == 1) begin
            hold_reg <= in_sample;
         end else begin
            latch_cnt <= LD_M1;
         end
      end else if (latch_cnt != '0) begin
         latch_cnt <= latch_cnt - 1'b1;
         if (latch_cnt == ONE) begin
            hold_reg <= in_sample;
         end
      end
   end

endmodule

// File: doc/i2s_sample_tx.md
Name: i2s_sample_tx

Overview:
- Serial audio transmitter at the DAC end of the sample path.
- Acts as the frame master: issues the new_sample_ready pulse that paces upstream blocks (echo, note players).
- Latches the resulting mono sample and shifts it out, MSB first, in a left-justified stereo serial stream (bclk, lrclk, sdata).
- The same sample is sent on both channels. One frame of latency.

Parameters:
- SAMPLE_WIDTH, 16, bits per channel slot; a frame is 2*SAMPLE_WIDTH bclk periods.
- BCLK_DIV, 4, clk cycles per bclk half-period; bclk period is 2*BCLK_DIV clk cycles. Must be >= 1.
- LATCH_DELAY, 2, clk cycles from a new_sample_ready pulse to the in_sample capture edge. Range 1..(frame clk cycles - 1).

Ports:
- clk, input, 1, system clock.
- reset, input, 1, asynchronous active-high reset.
- in_sample, input, SAMPLE_WIDTH, signed sample from upstream, valid LATCH_DELAY cycles after new_sample_ready.
- tx_enable, input, 1, when 0 sdata is forced to 0; clocks and pulses continue.
- new_sample_ready, output, 1, one-clk pulse per frame requesting the next sample.
- bclk, output, 1, serial bit clock.
- lrclk, output, 1, 0 = left slot, 1 = right slot.
- sdata, output, 1, serial data, changes only on bclk falling edges.

Behaviour:
- Reset (async, immediate): all outputs are 0.
  - div_cnt = 0, bit_cnt = 2*SAMPLE_WIDTH-1, hold_reg = 0, shift_reg = 0, latch_cnt idle.
- Divider: div_cnt counts 0..BCLK_DIV-1. On wrap, bclk toggles. A falling event is a wrap with bclk == 1.
- On each falling event, bit_cnt increments modulo 2*SAMPLE_WIDTH.
- lrclk = (bit_cnt >= SAMPLE_WIDTH), registered and updated on the same edge.
- Frame boundary is a falling event with bit_cnt == 2*SAMPLE_WIDTH-1. On that edge:
  - bit_cnt goes to 0.
  - shift_reg loads {hold_reg, hold_reg}.
  - sdata takes the MSB of hold_reg (or 0 if tx_enable == 0).
  - new_sample_ready is 1 for exactly this one clk.
- Other falling events: shift_reg shifts left by 1, and sdata takes the new MSB (or 0 if tx_enable == 0).
- Capture: LATCH_DELAY clk cycles after new_sample_ready is high, hold_reg <= in_sample.
  - The sample requested in frame N is transmitted in frame N+1.
  - The latch counter restarts on every pulse. Overlap cannot occur within the legal LATCH_DELAY range.
- First pulse after reset deassertion: 2*BCLK_DIV clk cycles later, on the first bclk falling edge. Frame 0 transmits zeros.
- Pulse spacing: exactly 4*SAMPLE_WIDTH*BCLK_DIV clk cycles (256 at defaults).
- tx_enable is sampled at each falling event and masks sdata only. Shifting proceeds regardless, so bit alignment is never lost.
- Reset mid-frame: outputs drop to 0 asynchronously. After release, timing restarts exactly as from power-up. Any pending capture is discarded.
- Signed data is sent as two's complement, unmodified; no clipping or scaling.

Decomposition:
- Shared package holds:
  - SAMPLE_WIDTH default and the frame-length constant FRAME_CLKS = 4*SAMPLE_WIDTH*BCLK_DIV (shared with the echo bench).
  - A signed sample typedef.
- One natural sub-module, bclk_gen: the divider. It outputs bclk and fall_evt strobes and owns div_cnt.
- Frame counter, capture and shifter stay in the top module.

Test Plan:
1. Reset, then release -> all outputs 0 during reset; bclk period 8 clk, 50% duty; first new_sample_ready at clk 8 after release; lrclk 0.
2. Pulse repeat -> next pulses at +256 clk, each exactly 1 clk wide; lrclk is high for 128 clk per frame, rising at bit_cnt 16.
3. Drive in_sample = 16'sd8000 (0x1F40) at the capture edge after pulse N -> during frame N+1, sdata sampled on bclk rising edges reads 0001111101000000 in the left slot and repeats in the right slot.
4. in_sample = -16'sd2000 (0xF830), tx_enable toggled 0 for one frame -> that frame's sdata is all 0; the next frame shows 0xF830 in both slots; pulses continue uninterrupted.
5. Assert reset at bit 9 of a frame carrying 0x1F40 -> outputs 0 within the same time step; after release, the first pulse comes at +8 clk and frame 0 is all zeros.
6. Loop with echo (delay 4, shift 2, enabled): impulse 8000 then zeros, bench deserializes sdata -> decoded stream shows 8000, then 2000 exactly 4 frames later; no value exceeds |32000|.
